// File: rtl/msb_word_serializer.sv
// MSB-first parallel-to-serial converter with valid/ready on both sides and
// sof/eof markers framing each word on the serial stream.
module msb_word_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             out_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             sof,
   output logic             eof
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_shreg;
   logic [CNT_W-1:0]   r_cnt;

   state_t             w_state_nxt;
   logic [WIDTH-1:0]   w_shreg_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_busy;
   logic               w_eof;
   logic               w_accept;
   logic               w_xfer;

   assign w_busy     = (r_state == ST_SHIFT);
   assign w_eof      = w_busy && (r_cnt == LAST_IDX);
   // in_ready must never look at in_valid, so the upstream handshake has no loop
   assign in_ready   = (r_state == ST_IDLE) || (w_eof && out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_xfer     = w_busy && out_ready;

   assign dout_valid = w_busy;
   assign dout       = w_busy ? r_shreg[WIDTH-1] : 1'b0;
   assign sof        = w_busy && (r_cnt == {CNT_W{1'b0}});
   assign eof        = w_eof;

   // Next-state: load on accept, shift on transfer, hold on stall.
   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_SHIFT;
               w_shreg_nxt = in_data;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (!w_xfer) begin
               w_state_nxt = ST_SHIFT;
            end else if (!w_eof) begin
               w_shreg_nxt = r_shreg << 1'b1;
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end else if (w_accept) begin
               // back-to-back reload on the last bit, no bubble
               w_state_nxt = ST_SHIFT;
               w_shreg_nxt = in_data;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_shreg_nxt = {WIDTH{1'b0}};
            w_cnt_nxt   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State, shift register and bit counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_shreg <= {WIDTH{1'b0}};
         r_cnt   <= {CNT_W{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_msb_word_serializer.sv
// Directed bench for msb_word_serializer (WIDTH=8) with a small serial mod-3
// remainder tracker standing in for the downstream checker.
module tb_msb_word_serializer;

   localparam int W = 8;

   logic         clk;
   logic         resetn;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_ready;
   logic         dout;
   logic         dout_valid;
   logic         sof;
   logic         eof;

   int total;
   int bad;
   logic [1:0] rem;

   msb_word_serializer #(.WIDTH(W)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_ready  (out_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .sof        (sof),
      .eof        (eof)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream mod-3 remainder of the serial word, restarted on sof.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rem <= 2'd0;
      end else if (dout_valid && out_ready) begin
         if (sof) rem <= {1'b0, dout};
         else     rem <= 2'(({30'd0, rem} * 32'd2 + {31'd0, dout}) % 32'd3);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one word with out_ready=1 and check its 8 bits plus the idle cycle after.
   task automatic send_word(input logic [W-1:0] w, input string tag);
      in_valid  = 1'b1;
      in_data   = w;
      out_ready = 1'b1;
      #1;
      chk({tag, " c0 in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, " c0 dout_valid"}, 64'(dout_valid), 64'd0);
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         #1;
         chk($sformatf("%s c%0d dout", tag, c), 64'(dout), 64'(w[8-c]));
         chk($sformatf("%s c%0d valid", tag, c), 64'(dout_valid), 64'd1);
         chk($sformatf("%s c%0d sof", tag, c), 64'(sof), 64'(c == 1));
         chk($sformatf("%s c%0d eof", tag, c), 64'(eof), 64'(c == 8));
         tick();
      end
      #1;
      chk({tag, " c9 dout_valid"}, 64'(dout_valid), 64'd0);
      chk({tag, " c9 in_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [15:0] stream;
      logic [7:0]  c3;
      logic [7:0]  ff;
      logic [7:0]  x5a;
      int          bi;

      total = 0;
      bad   = 0;
      resetn    = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      #12;
      chk("reset dout_valid", 64'(dout_valid), 64'd0);
      chk("reset dout", 64'(dout), 64'd0);
      chk("reset sof", 64'(sof), 64'd0);
      chk("reset eof", 64'(eof), 64'd0);
      chk("reset in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #2;
      resetn = 1'b1;
      tick();

      // 1: single word A5
      send_word(8'hA5, "t1");
      tick();

      // 2: back-to-back 03 then 0F
      stream    = 16'h030F;
      in_valid  = 1'b1;
      in_data   = 8'h03;
      out_ready = 1'b1;
      #1;
      chk("t2 c0 in_ready", 64'(in_ready), 64'd1);
      tick();
      in_data = 8'h0F;
      for (int c = 1; c <= 16; c++) begin
         if (c == 9) in_valid = 1'b0;
         #1;
         chk($sformatf("t2 c%0d dout", c), 64'(dout), 64'(stream[16-c]));
         chk($sformatf("t2 c%0d valid", c), 64'(dout_valid), 64'd1);
         chk($sformatf("t2 c%0d sof", c), 64'(sof), 64'(c == 1 || c == 9));
         if (c <= 8)
            chk($sformatf("t2 c%0d in_ready", c), 64'(in_ready), 64'(c == 8));
         tick();
      end
      #1;
      chk("t2 c17 dout_valid", 64'(dout_valid), 64'd0);
      tick();

      // 3: backpressure on bit 4 of C3
      c3       = 8'hC3;
      in_valid = 1'b1;
      in_data  = c3;
      #1;
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         out_ready = !(c >= 4 && c <= 6);
         if (c <= 4)      bi = 8 - c;
         else if (c <= 7) bi = 4;
         else             bi = 11 - c;
         #1;
         chk($sformatf("t3 c%0d dout", c), 64'(dout), 64'(c3[bi]));
         chk($sformatf("t3 c%0d valid", c), 64'(dout_valid), 64'd1);
         chk($sformatf("t3 c%0d sof", c), 64'(sof), 64'(c == 1));
         chk($sformatf("t3 c%0d eof", c), 64'(eof), 64'(c == 11));
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("t3 c12 dout_valid", 64'(dout_valid), 64'd0);
      tick();

      // 4: async reset while bit 3 of FF is on dout
      ff       = 8'hFF;
      in_valid = 1'b1;
      in_data  = ff;
      #1;
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= 4; c++) tick();
      #1;
      chk("t4 pre-reset dout", 64'(dout), 64'd1);
      chk("t4 pre-reset valid", 64'(dout_valid), 64'd1);
      #2;
      resetn = 1'b0;
      #1;
      chk("t4 async dout_valid", 64'(dout_valid), 64'd0);
      chk("t4 async dout", 64'(dout), 64'd0);
      chk("t4 async sof", 64'(sof), 64'd0);
      chk("t4 async eof", 64'(eof), 64'd0);
      chk("t4 async in_ready", 64'(in_ready), 64'd1);
      tick();
      resetn = 1'b1;
      tick();
      #1;
      chk("t4 post-release dout_valid", 64'(dout_valid), 64'd0);
      send_word(8'h01, "t4b");
      tick();

      // 5: in_data toggling while busy with 5A
      x5a      = 8'h5A;
      in_valid = 1'b1;
      in_data  = x5a;
      #1;
      tick();
      for (int c = 1; c <= 8; c++) begin
         in_data  = ~in_data;
         in_valid = (c != 8);
         #1;
         chk($sformatf("t5 c%0d dout", c), 64'(dout), 64'(x5a[8-c]));
         if (c < 8) chk($sformatf("t5 c%0d in_ready", c), 64'(in_ready), 64'd0);
         tick();
      end
      #1;
      chk("t5 c9 dout_valid", 64'(dout_valid), 64'd0);
      tick();

      // 6: downstream mod-3 result after eof
      send_word(8'h0F, "t6a");
      chk("t6 0F divisible", 64'(rem == 2'd0), 64'd1);
      tick();
      send_word(8'h10, "t6b");
      chk("t6 10 divisible", 64'(rem == 2'd0), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/msb_word_serializer.md
Name: msb_word_serializer

Overview:
Parallel-to-serial front end for the serial mod-3 divisibility checker. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per transfer, MSB first, on a single-bit stream. It also emits sof/eof frame markers, which the integration layer uses to clear the downstream checker between words. Both sides are handshaked, so the block can be throttled by a downstream stall.

Parameters:
WIDTH, 8, word width in bits; legal range 1 to 64.
CNT_W, $clog2(WIDTH) with a minimum of 1, bit-index counter width (derived; do not override).

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
in_valid  input  1  in_data holds a word to be serialized
in_ready  output  1  block accepts a word this cycle
in_data  input  WIDTH  parallel word
out_ready  input  1  downstream consumes dout this cycle
dout  output  1  current serial bit (MSB first)
dout_valid  output  1  dout carries a valid bit
sof  output  1  dout is bit WIDTH-1 (first bit) of a word
eof  output  1  dout is bit 0 (last bit) of a word

Behaviour:
- Reset is asynchronous on the resetn falling edge.
  - State goes to IDLE; shift register and counter go to 0.
  - dout=0, dout_valid=0, sof=0, eof=0, in_ready=1 (in IDLE).
  - Release is synchronous to clk.
- States are IDLE and SHIFT, registered. cnt counts bits already transferred in the current word.
- dout_valid = (state==SHIFT).
- dout = shreg[WIDTH-1] in SHIFT, 0 in IDLE.
- sof = dout_valid && cnt==0.
- eof = dout_valid && cnt==WIDTH-1.
- in_ready = IDLE || (SHIFT && eof && out_ready). It depends only on state and out_ready, never on in_valid.
- Accept: in_valid && in_ready at a clock edge.
  - shreg <= in_data, cnt <= 0, state <= SHIFT.
  - First bit is visible the cycle after acceptance (latency 1).
- Bit transfer: dout_valid && out_ready at a clock edge.
  - If not eof: shreg shifts left by 1 (zero fill) and cnt increments.
  - If eof and an accept happens in the same cycle: reload as for accept, with no bubble cycle.
  - If eof and no accept: state <= IDLE.
- Stall: out_ready=0 in SHIFT freezes shreg, cnt and state; dout, sof and eof hold stable. in_valid/in_data changes during SHIFT are ignored, except in an accepting eof cycle.
- WIDTH=1: sof and eof are both high on the single bit.
- The counter never exceeds WIDTH-1. No wrap past eof.
- Reset mid-word discards the partial word. No residual bits are emitted after release.
- Stream contract: every accepted word produces exactly WIDTH transfers, sof on the first and eof on the last.

Test Plan:
1. WIDTH=8, out_ready=1, accept 8'hA5 at edge 0 -> dout over cycles 1..8 = 1,0,1,0,0,1,0,1. sof=1 in cycle 1 only, eof=1 in cycle 8 only. dout_valid=0 and in_ready=1 in cycle 9.
2. Back-to-back: in_valid held with 8'h03 then 8'h0F -> 16 contiguous valid cycles with stream 00000011 00001111. in_ready=1 only in cycle 0 and cycle 8 (eof). Second sof in cycle 9.
3. Backpressure: 8'hC3, out_ready=0 for 3 cycles while dout is bit 4 -> dout=0 and dout_valid=1 held for 4 cycles. Word completes in 11 cycles; eof is not asserted early.
4. Async reset: resetn driven low mid-cycle at bit 3 of 8'hFF -> dout_valid, dout, sof and eof drop to 0 before the next clock edge. After release, 8'h01 serializes cleanly as 0000_0001.
5. in_data toggled each cycle while busy with 8'h5A -> stream is still 01011010. No extra word is accepted before eof.
6. Integration with the downstream mod-3 checker, cleared on sof: 8'h0F (15) -> checker reports divisible after eof; 8'h10 (16) -> not divisible.
